// File: rtl/mem_port_arbiter_if.sv
// Shared-RAM port bundle: fetch and data requesters plus the single synchronous RAM port.
// slave is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one synchronous RAM port: combinational grant, read data 2 cycles later, one read in flight.
// Requesters hold req until gnt; ARB_STARVE_GUARD_EN forces a fetch grant after STARVE_LIMIT denials.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q;
  logic        owner_if_q;
  logic        if_rvalid_q;
  logic        d_rvalid_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic idle;
  logic starve_force;
  logic fetch_wins;
  logic if_gnt;
  logic d_gnt;
  logic rd_gnt;

  // Grants are gated by reset so every output drops the instant rst_n falls.
  assign idle       = rst_n && (state_q == S_IDLE);
  assign fetch_wins = bus.if_req && (!bus.d_req || starve_force);
  assign if_gnt     = idle && fetch_wins;
  assign d_gnt      = idle && bus.d_req && !fetch_wins;
  assign rd_gnt     = if_gnt || (d_gnt && !bus.d_we);

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.ram_addr  = if_gnt ? bus.if_addr : (d_gnt ? bus.d_addr : '0);
  assign bus.ram_wdata = d_gnt ? bus.d_wdata : 32'd0;
  assign bus.ram_we    = d_gnt && bus.d_we;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned    CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  // Counts IDLE cycles in which a waiting fetch lost to data; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (idle && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_force = (starve_cnt_q == LIMIT);
`else
  // Strict data priority; the limit is only referenced so the parameter stays live.
  assign starve_force = 1'b0 & (STARVE_LIMIT == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_if_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd_gnt) begin
            state_q    <= S_WAIT;
            owner_if_q <= if_gnt;
          end
        end
        S_WAIT: begin
          // RAM data for the address granted last cycle is valid now.
          state_q <= S_IDLE;
          if (owner_if_q) begin
            if_rdata_q  <= bus.ram_rdata;
            if_rvalid_q <= 1'b1;
          end else begin
            d_rdata_q  <= bus.ram_rdata;
            d_rvalid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: a reference memory predicts read data at issue time,
// a negedge monitor pops and compares on every rvalid. Build with ARB_STARVE_GUARD_EN to test the guard.
module tb_mem_port_arbiter;
  localparam int unsigned AW    = 8;
  localparam int unsigned LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 'h10) return 32'hE3A01005;
    if (i == 'h20) return 32'hDEADBEEF;
    return 32'h5A5A0000 + 32'(i);
  endfunction

  // Synchronous RAM model: data for the presented address appears the next cycle.
  logic [31:0] ram_mem [0:255];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  logic [31:0] ref_mem [0:255];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  int cyc        = 0;
  int if_gnt_cyc = 0;
  int d_gnt_cyc  = 0;
  int d_gnt_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      check_val("gnt_onehot", {63'd0, bus.if_gnt & bus.d_gnt}, 64'd0);
      if (!bus.if_gnt && !bus.d_gnt)
        check_val("ram_idle", {23'd0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 64'd0);
      if (bus.if_rvalid) begin
        if (if_q.size() == 0) check_val("if_rvalid_unexpected", 64'd1, 64'd0);
        else begin
          check_val("if_rdata", {32'd0, bus.if_rdata}, {32'd0, if_q.pop_front()});
          check_val("if_latency", 64'(cyc - if_gnt_cyc), 64'd2);
        end
      end
      if (bus.d_rvalid) begin
        if (d_q.size() == 0) check_val("d_rvalid_unexpected", 64'd1, 64'd0);
        else begin
          check_val("d_rdata", {32'd0, bus.d_rdata}, {32'd0, d_q.pop_front()});
          check_val("d_latency", 64'(cyc - d_gnt_cyc), 64'd2);
        end
      end
      if (bus.if_gnt) if_gnt_cyc <= cyc;
      if (bus.d_gnt) begin
        d_gnt_cnt <= d_gnt_cnt + 1;
        if (!bus.d_we) d_gnt_cyc <= cyc;
      end
    end
  end

  task automatic wait_gnt(input bit is_if, output int gc);
    bit got = 1'b0;
    gc = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = is_if ? bus.if_gnt : bus.d_gnt;
    end
    if (got) gc = cyc;
    else check_val(is_if ? "if_gnt_timeout" : "d_gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic fetch_read(input logic [AW-1:0] a, output int gc);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    if_q.push_back(ref_mem[a]);
    wait_gnt(1'b1, gc);
    if (gc >= 0) check_val("if_ram_addr", {56'd0, bus.ram_addr}, {56'd0, a});
    @(posedge clk); #1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
  endtask

  task automatic data_op(input bit we, input logic [AW-1:0] a, input logic [31:0] wd, output int gc);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = we ? wd : 32'd0;
    if (we) ref_mem[a] = wd;
    else d_q.push_back(ref_mem[a]);
    wait_gnt(1'b0, gc);
    if (gc >= 0) begin
      check_val("d_ram_we", {63'd0, bus.ram_we}, {63'd0, we});
      check_val("d_ram_addr", {56'd0, bus.ram_addr}, {56'd0, a});
      if (we) check_val("d_ram_wdata", {32'd0, bus.ram_wdata}, {32'd0, wd});
    end
    @(posedge clk); #1;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = 32'd0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_gnt"}, {62'd0, bus.if_gnt, bus.d_gnt}, 64'd0);
    check_val({tag, "_rvalid"}, {62'd0, bus.if_rvalid, bus.d_rvalid}, 64'd0);
    check_val({tag, "_if_rdata"}, {32'd0, bus.if_rdata}, 64'd0);
    check_val({tag, "_d_rdata"}, {32'd0, bus.d_rdata}, 64'd0);
    check_val({tag, "_ram"}, {23'd0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 64'd0);
  endtask

  int gd, gf, gw, d_start, d_before;
  int wc [3];

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single fetch read.
    fetch_read(8'h10, gf);
    repeat (3) @(posedge clk); #1;

    // Simultaneous requests: data first, fetch granted two cycles later.
    fork
      data_op(1'b0, 8'h20, 32'd0, gd);
      fetch_read(8'h11, gf);
    join
    check_val("prio_if_after_d", 64'(gf - gd), 64'd2);
    repeat (4) @(posedge clk); #1;

    // Back-to-back writes, then read them back through both requesters.
    for (int i = 0; i < 3; i++) data_op(1'b1, 8'(8'h30 + i), 32'hA5000030 + 32'(i), wc[i]);
    check_val("wr_b2b_1", 64'(wc[1] - wc[0]), 64'd1);
    check_val("wr_b2b_2", 64'(wc[2] - wc[1]), 64'd1);
    data_op(1'b0, 8'h30, 32'd0, gd);
    fetch_read(8'h31, gf);
    data_op(1'b0, 8'h32, 32'd0, gd);
    repeat (4) @(posedge clk); #1;

    // Held fetch against a stream of data writes.
    d_start = d_gnt_cnt;
    fork
      for (int i = 0; i < 8; i++) data_op(1'b1, 8'(8'h40 + i), 32'h11110000 + 32'(i), gw);
      begin
        fetch_read(8'h12, gf);
        d_before = d_gnt_cnt - d_start;
      end
    join
`ifdef ARB_STARVE_GUARD_EN
    check_val("starve_d_before_if", 64'(d_before), 64'(LIMIT));
`else
    check_val("starve_d_before_if", 64'(d_before), 64'd8);
`endif
    repeat (4) @(posedge clk); #1;
    fetch_read(8'h45, gf);
    repeat (4) @(posedge clk); #1;

    // Reset during an in-flight read drops it.
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    @(negedge clk);
    check_val("rst_pre_gnt", {63'd0, bus.if_gnt}, 64'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    #1 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    fetch_read(8'h13, gf);
    repeat (3) @(posedge clk); #1;

    // Fetch request that only exists during WAIT must be ignored.
    data_op(1'b0, 8'h21, 32'd0, gd);
    bus.if_req = 1'b1; bus.if_addr = 8'h55;
    @(negedge clk);
    check_val("wait_no_gnt", {63'd0, bus.if_gnt}, 64'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    @(negedge clk);
    check_val("withdrawn_no_gnt", {63'd0, bus.if_gnt}, 64'd0);
    check_val("withdrawn_ram_addr", {56'd0, bus.ram_addr}, 64'd0);
    repeat (5) @(posedge clk); #1;

    check_val("if_q_drained", 64'(if_q.size()), 64'd0);
    check_val("d_q_drained", 64'(d_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no completion, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
